// File: rtl/load_store_unit_pkg.sv
// Shared RV32I/RV64I type definitions: load/store funct3 encodings, the
// load/store unit state type and the request legality check.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    RESP
  } lsu_state_t;

  // Doubleword and LWU encodings only exist on a 64-bit datapath.
  function automatic logic lsu_illegal(input logic store, input logic [2:0] funct3,
                                       input int xlen);
    if (funct3 == 3'b111) return 1'b1;
    if (store && funct3[2]) return 1'b1;
    if (xlen == 32 && (funct3 == 3'(LD) || funct3 == 3'(LWU))) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane mask generation, store data rotation and
// load byte extraction with sign/zero extension for the load/store unit.
module lsu_align
  import rv32i_types::*;
#(
  parameter  int XLEN  = 32,
  localparam int BYTES = XLEN / 8,
  localparam int OFF_W = $clog2(BYTES)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rword_lo,
  input  logic [XLEN-1:0]  rword_hi,
  output logic [BYTES-1:0] mask_lo,
  output logic [BYTES-1:0] mask_hi,
  output logic [XLEN-1:0]  wdata_lo,
  output logic [XLEN-1:0]  wdata_hi,
  output logic [XLEN-1:0]  rdata,
  output logic             crossing,
  output logic             misaligned
);

  function automatic logic [XLEN-1:0] lane_bits(input logic [BYTES-1:0] lanes);
    logic [XLEN-1:0] bits;
    for (int i = 0; i < BYTES; i++) bits[8*i +: 8] = {8{lanes[i]}};
    return bits;
  endfunction

  // Extend the low (8 << funct3[1:0]) bits to XLEN; funct3[2] selects zero extension.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [2:0] f3);
    logic [XLEN-1:0] keep;
    int              nbits;
    logic            sgn;
    nbits = 8 << f3[1:0];
    if (nbits > XLEN) nbits = XLEN;
    for (int i = 0; i < XLEN; i++) keep[i] = (i < nbits);
    sgn = ~f3[2] & raw[nbits-1];
    return (raw & keep) | ({XLEN{sgn}} & ~keep);
  endfunction

  int                 size;
  logic [BYTES-1:0]   size_keep;
  logic [2*BYTES-1:0] lane_span;
  logic [2*XLEN-1:0]  wide_w;
  logic [2*XLEN-1:0]  wide_r;

  always_comb begin
    size = 1 << funct3[1:0];
    for (int i = 0; i < BYTES; i++) size_keep[i] = (i < size);
    // A double-width view lets one shift cover both halves of a split access.
    lane_span = {{BYTES{1'b0}}, size_keep} << offset;
    mask_lo   = lane_span[BYTES-1:0];
    mask_hi   = lane_span[2*BYTES-1:BYTES];
    wide_w    = {{XLEN{1'b0}}, wdata & lane_bits(size_keep)} << {offset, 3'b000};
    wdata_lo  = wide_w[XLEN-1:0];
    wdata_hi  = wide_w[2*XLEN-1:XLEN];
    wide_r    = {rword_hi & lane_bits(mask_hi), rword_lo & lane_bits(mask_lo)}
                >> {offset, 3'b000};
    rdata      = extend(wide_r[XLEN-1:0], funct3);
    crossing   = (int'(offset) + size) > BYTES;
    misaligned = (offset & OFF_W'(size - 1)) != '0;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequential load/store engine driving a word-wide memory port.
// Define LSU_MISALIGNED_EN to execute misaligned requests (split when crossing).
module load_store_unit
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int BYTES = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_fault,
  output logic             mem_read,
  output logic             mem_write,
  output logic [XLEN-1:0]  mem_address,
  output logic [BYTES-1:0] mem_byte_enable,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_resp
);

  localparam int OFF_W = $clog2(BYTES);
`ifdef LSU_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  lsu_state_t       state;
  logic [2:0]       f3_q;
  logic             store_q;
  logic [OFF_W-1:0] offset_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  cap_lo;

  logic [2:0]       a_f3;
  logic [OFF_W-1:0] a_off;
  logic [XLEN-1:0]  a_wdata;
  logic [XLEN-1:0]  a_lo;
  logic [XLEN-1:0]  a_hi;
  logic [BYTES-1:0] mask_lo;
  logic [BYTES-1:0] mask_hi;
  logic [XLEN-1:0]  wdata_lo;
  logic [XLEN-1:0]  wdata_hi;
  logic [XLEN-1:0]  ld_data;
  logic             crossing;
  logic             misaligned;
  logic             fault_now;

  assign req_ready = (state == IDLE);

  // While idle the aligner looks at the incoming request; afterwards at the latched one.
  always_comb begin
    a_f3    = f3_q;
    a_off   = offset_q;
    a_wdata = wdata_q;
    if (state == IDLE) begin
      a_f3    = req_funct3;
      a_off   = req_addr[OFF_W-1:0];
      a_wdata = req_wdata;
    end
    a_lo = (state == ACC1) ? mem_rdata : cap_lo;
    a_hi = (state == ACC2) ? mem_rdata : '0;
  end

  assign fault_now = lsu_illegal(req_store, req_funct3, XLEN) | (misaligned & ~MIS_EN);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (a_f3),
    .offset    (a_off),
    .wdata     (a_wdata),
    .rword_lo  (a_lo),
    .rword_hi  (a_hi),
    .mask_lo   (mask_lo),
    .mask_hi   (mask_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .rdata     (ld_data),
    .crossing  (crossing),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      f3_q            <= '0;
      store_q         <= 1'b0;
      offset_q        <= '0;
      wdata_q         <= '0;
      cap_lo          <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_fault      <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_byte_enable <= '0;
      mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            f3_q     <= req_funct3;
            store_q  <= req_store;
            offset_q <= req_addr[OFF_W-1:0];
            wdata_q  <= req_wdata;
            cap_lo   <= '0;
            if (fault_now) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state           <= ACC1;
              mem_read        <= ~req_store;
              mem_write       <= req_store;
              mem_address     <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              mem_byte_enable <= mask_lo;
              mem_wdata       <= req_store ? wdata_lo : '0;
            end
          end
        end
        ACC1: begin
          if (mem_resp) begin
            cap_lo <= mem_rdata;
            if (crossing) begin
              // Second word follows immediately; address wraps naturally at 2^XLEN.
              state           <= ACC2;
              mem_address     <= mem_address + XLEN'(BYTES);
              mem_byte_enable <= mask_hi;
              mem_wdata       <= store_q ? wdata_hi : '0;
            end else begin
              state           <= RESP;
              mem_read        <= 1'b0;
              mem_write       <= 1'b0;
              mem_byte_enable <= '0;
              mem_wdata       <= '0;
              resp_valid      <= 1'b1;
              resp_fault      <= 1'b0;
              resp_rdata      <= store_q ? '0 : ld_data;
            end
          end
        end
        ACC2: begin
          if (mem_resp) begin
            state           <= RESP;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
            resp_valid      <= 1'b1;
            resp_fault      <= 1'b0;
            resp_rdata      <= store_q ? '0 : ld_data;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised memory access unit that replaces the fixed MAR/MDR/load-format/store-format path of the multicycle datapath with a self-contained sequential block. It accepts one load or store request from the control FSM and drives a word-wide memory port with a read/write–mem_resp handshake. It performs byte-lane steering, sign or zero extension, and split accesses for misaligned requests. Width is set by `XLEN` (32 or 64), so the same block serves an RV64 successor.

## Interface
Parameters:
- XLEN, 32, data and address width; legal values 32, 64
- BYTES, XLEN/8, derived, lanes per memory word (not to be overridden)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V load/store funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD)
- req_addr  in  XLEN  byte address (rs1 + imm)
- req_wdata  in  XLEN  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores and faults
- resp_fault  out  1  illegal funct3, or misaligned with feature disabled
- mem_read / mem_write  out  1 each  memory strobes, held until mem_resp
- mem_address  out  XLEN  word-aligned address (low log2(BYTES) bits 0)
- mem_byte_enable  out  BYTES  active lanes
- mem_wdata  out  XLEN  lane-steered store data; disabled lanes 0
- mem_rdata  in  XLEN  read data, valid when mem_resp
- mem_resp  in  1  access complete

## Operation
- Size = 1 << funct3[1:0]. Unsigned = funct3[2] (loads only).
- Illegal encodings produce fault; no memory access.
  - Always illegal: funct3 = 111, and any store with funct3[2] = 1.
  - Illegal when XLEN = 32: size 8 (011) and LWU (110).
- Offset = addr[log2(BYTES)-1:0]. Misaligned = addr mod size ≠ 0. Crossing = offset + size > BYTES.
- FSM states: IDLE, ACC1, ACC2, RESP.
  - IDLE: req_ready = 1. On req_valid, latch the request.
    - Go to RESP with fault if illegal, or misaligned with the feature disabled.
    - Otherwise go to ACC1.
  - ACC1: access aligned(addr) on lanes offset .. min(offset+size, BYTES)-1. Hold the strobe until mem_resp. On mem_resp, capture the enabled lanes. Go to ACC2 if crossing, else RESP.
  - ACC2: access aligned(addr) + BYTES, wrapping modulo 2^XLEN, on lanes 0 .. offset+size-BYTES-1. Hold until mem_resp, capture, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Loads:
  - Captured bytes are concatenated in little-endian order from the first access, then the second.
  - The result is sign- or zero-extended from size*8 bits to XLEN.
  - Load mem_byte_enable shows the lanes actually used.
- Stores:
  - Low size bytes of req_wdata are rotated to lanes starting at offset.
  - ACC2 carries the remaining upper bytes starting at lane 0.
- A faulted store never asserts mem_write.
- mem_read and mem_write are never asserted together.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_fault 0, mem_read 0, mem_write 0, mem_address 0, mem_byte_enable 0, mem_wdata 0.
- All outputs are registered except req_ready, which is (state == IDLE).
- Request accepted at edge 0 → strobe asserted from cycle 1.
- With mem_resp in the first strobe cycle: resp_valid in cycle 2 for an aligned access, cycle 3 for a split access.
- Each memory wait cycle adds one cycle to latency.
- A fault responds in cycle 1.
- Strobes deassert in the cycle after mem_resp is sampled. There is no back-to-back strobe with stale address.
- A new request is accepted in the cycle resp_valid is high only if state has returned to IDLE. It is not: the earliest acceptance is the cycle after resp_valid.
- rst mid-access abandons the operation. Strobes are 0 from the next cycle, no resp_valid is produced, and a late mem_resp in IDLE is ignored.
- req_valid while not ready is ignored; the requester holds it.

## Configuration
- LSU_MISALIGNED_EN defined: misaligned requests are executed, using a split ACC1/ACC2 access when crossing.
- LSU_MISALIGNED_EN undefined: any misaligned request returns resp_fault = 1 with no memory access, and ACC2 is unreachable.

## Structure
- Shared package rv32i_types gains:
  - load_funct3_t and store_funct3_t (add LD/LWU/SD encodings)
  - lsu_state_t {IDLE, ACC1, ACC2, RESP}
- One combinational sub-module, lsu_align, handles lane mask generation, store rotation and load extraction/extension. It is parametrised by XLEN.
- The FSM and capture registers stay in load_store_unit.

## Test plan
- XLEN=32, LW 0x100, mem_rdata 0xDEADBEEF, mem_resp after 2 waits → mem_address 0x100, enable 1111, resp_rdata 0xDEADBEEF, resp_valid in cycle 4.
- LB 0x103, rdata 0x80xxxxxx → enable 1000, result 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0x102, wdata 0x1234ABCD → enable 1100, mem_wdata 0xABCD0000, one write only.
- With LSU_MISALIGNED_EN, LW 0x0FE → reads 0x0FC lanes 1100 (0x5678xxxx), then 0x100 lanes 0011 (0xxxxx1234), result 0x12345678. Without the macro → fault in cycle 1, no strobe.
- Illegal funct3 111, and LD with XLEN=32 → resp_fault 1, resp_rdata 0, no memory access. XLEN=64 LD 0x8 → enable 0xFF.
- SW to 0xFFFFFFFE (feature on) → second write at 0x00000000 (wrap). rst asserted while in ACC2 → strobes 0 the next cycle, no resp_valid, req_ready 1.
